bcd_countdown_timer: RTL

//  MM:SS BCD down-counter; the count-down counterpart of the MM:SS up-counting clock.

---
 rtl/bcd_countdown_timer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer: loads four clamped BCD digits, decrements once per prescaled tick,
// pauses/resumes on start pulses and flags expiry at 00:00.
module bcd_countdown_timer #(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input  logic       clk,
   input  logic       clear_n,
   input  logic       load,
   input  logic       start,
   input  logic [3:0] set_tm,
   input  logic [3:0] set_om,
   input  logic [3:0] set_ts,
   input  logic [3:0] set_os,
   output logic [3:0] tm,
   output logic [3:0] om,
   output logic [3:0] ts,
   output logic [3:0] os,
   output logic       running,
   output logic       expired,
   output logic       expire_pulse
);

   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PSC_MAX = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PSC_ONE = PW'(1);

   typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

   state_e        state_q;
   logic [PW-1:0] presc_q;
   logic [3:0]    tm_q, om_q, ts_q, os_q;
   logic          running_q, expired_q, pulse_q;

   logic [3:0]    tm_dec, om_dec, ts_dec, os_dec;
   logic          tick;
   logic          dec_zero;
   logic          count_zero;

   function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   assign tick       = (state_q == StRun) && (presc_q == PSC_MAX);
   assign count_zero = ({tm_q, om_q, ts_q, os_q} == 16'h0000);

   // Borrow chain; tm never borrows because the run stops at 00:00.
   always_comb begin
      tm_dec = tm_q;
      om_dec = om_q;
      ts_dec = ts_q;
      os_dec = os_q - 4'd1;
      if (os_q == 4'd0) begin
         os_dec = 4'd9;
         if (ts_q == 4'd0) begin
            ts_dec = 4'd5;
            if (om_q == 4'd0) begin
               om_dec = 4'd9;
               tm_dec = tm_q - 4'd1;
            end else begin
               om_dec = om_q - 4'd1;
            end
         end else begin
            ts_dec = ts_q - 4'd1;
         end
      end
   end

   assign dec_zero = ({tm_dec, om_dec, ts_dec, os_dec} == 16'h0000);

   always_ff @(posedge clk) begin
      if (!clear_n) begin
         state_q   <= StIdle;
         presc_q   <= '0;
         tm_q      <= 4'd0;
         om_q      <= 4'd0;
         ts_q      <= 4'd0;
         os_q      <= 4'd0;
         running_q <= 1'b0;
         expired_q <= 1'b0;
         pulse_q   <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         if (load) begin
            tm_q      <= clamp(set_tm, 4'd5);
            om_q      <= clamp(set_om, 4'd9);
            ts_q      <= clamp(set_ts, 4'd5);
            os_q      <= clamp(set_os, 4'd9);
            presc_q   <= '0;
            state_q   <= StIdle;
            running_q <= 1'b0;
            expired_q <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  presc_q <= '0;
                  if (start && !count_zero) begin
                     state_q   <= StRun;
                     running_q <= 1'b1;
                  end
               end
               StRun: begin
                  if (tick) begin
                     presc_q <= '0;
                     tm_q    <= tm_dec;
                     om_q    <= om_dec;
                     ts_q    <= ts_dec;
                     os_q    <= os_dec;
                     // Reaching 00:00 takes priority over a coincident start.
                     if (dec_zero) begin
                        state_q   <= StDone;
                        running_q <= 1'b0;
                        expired_q <= 1'b1;
                        pulse_q   <= 1'b1;
                     end else if (start) begin
                        state_q   <= StPause;
                        running_q <= 1'b0;
                     end
                  end else begin
                     presc_q <= presc_q + PSC_ONE;
                     if (start) begin
                        state_q   <= StPause;
                        running_q <= 1'b0;
                     end
                  end
               end
               StPause: begin
                  if (start) begin
                     state_q   <= StRun;
                     running_q <= 1'b1;
                  end
               end
               StDone: begin
                  presc_q <= '0;
               end
               default: begin
                  state_q   <= StIdle;
                  presc_q   <= '0;
                  running_q <= 1'b0;
                  expired_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign tm           = tm_q;
   assign om           = om_q;
   assign ts           = ts_q;
   assign os           = os_q;
   assign running      = running_q;
   assign expired      = expired_q;
   assign expire_pulse = pulse_q;

endmodule
